// File: rtl/param_field_loader.sv
// Loads a packed config word into a downstream unit one FIELD_W field per write beat.
// Latency: start->done = NUM_FIELDS+2 cycles with no stalls (+1 cycle per field plus read stalls with readback).
// Backpressure: each wr (and rd) beat holds addr/data until its ready; TIMEOUT stalled cycles abort with err.
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   start, cfg_word     : one-cycle load request and the word it captures
//   busy, done, err     : load in progress / one-cycle completion pulse / sticky failure flag
//   wr_valid/wr_ready   : write beat handshake, wr_addr = field index, wr_data = field value
//   rd_valid/rd_ready   : readback handshake, rd_addr = field index, rd_data = returned value
// Optional feature macro: PARAM_FIELD_LOADER_READBACK_EN adds the rd_* ports and a
// verify-after-write step per field. Without it the rd_* ports do not exist.
module param_field_loader #(
    parameter int WORD_W  = 16,
    parameter int FIELD_W = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WORD_W-1:0]  cfg_word,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               wr_valid,
    input  logic               wr_ready,
    output logic [ADDR_W-1:0]  wr_addr,
    output logic [FIELD_W-1:0] wr_data
`ifdef PARAM_FIELD_LOADER_READBACK_EN
    ,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [FIELD_W-1:0] rd_data
`endif
);

    localparam int NUM_FIELDS = WORD_W / FIELD_W;
    localparam int CNT_W      = $clog2(TIMEOUT + 1);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_FIELDS - 1);
    // Abort happens on the edge that ends the TIMEOUT-th consecutive stalled cycle.
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_DONE
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   idx;
    logic [CNT_W-1:0]    stall_cnt;
    logic [WORD_W-1:0]   shadow;
    logic [FIELD_W-1:0]  cur_field;

    // Address and data come straight from registers, so they are stable for
    // as long as idx and shadow are, i.e. across a stalled beat.
    assign cur_field = shadow[idx*FIELD_W +: FIELD_W];
    assign wr_addr   = idx;
    assign wr_data   = cur_field;
`ifdef PARAM_FIELD_LOADER_READBACK_EN
    assign rd_addr   = idx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            stall_cnt <= '0;
            shadow    <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            wr_valid  <= 1'b0;
`ifdef PARAM_FIELD_LOADER_READBACK_EN
            rd_valid  <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shadow    <= cfg_word;
                        idx       <= '0;
                        stall_cnt <= '0;
                        err       <= 1'b0;
                        busy      <= 1'b1;
                        wr_valid  <= 1'b1;
                        state     <= ST_WRITE;
                    end
                end

                ST_WRITE: begin
                    if (wr_ready) begin
                        stall_cnt <= '0;
`ifdef PARAM_FIELD_LOADER_READBACK_EN
                        // Verify this field before moving on; idx stays put.
                        wr_valid  <= 1'b0;
                        rd_valid  <= 1'b1;
                        state     <= ST_READ;
`else
                        if (idx == LAST_IDX) begin
                            wr_valid <= 1'b0;
                            state    <= ST_DONE;
                        end else begin
                            idx <= idx + 1'b1;
                        end
`endif
                    end else if (stall_cnt == CNT_LIMIT) begin
                        // Give up: fields already written stay written.
                        wr_valid  <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        idx       <= '0;
                        stall_cnt <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
                end

                ST_READ: begin
`ifdef PARAM_FIELD_LOADER_READBACK_EN
                    if (rd_ready) begin
                        stall_cnt <= '0;
                        rd_valid  <= 1'b0;
                        if (rd_data != cur_field) begin
                            err   <= 1'b1;
                            busy  <= 1'b0;
                            idx   <= '0;
                            state <= ST_IDLE;
                        end else if (idx == LAST_IDX) begin
                            state <= ST_DONE;
                        end else begin
                            idx      <= idx + 1'b1;
                            wr_valid <= 1'b1;
                            state    <= ST_WRITE;
                        end
                    end else if (stall_cnt == CNT_LIMIT) begin
                        rd_valid  <= 1'b0;
                        err       <= 1'b1;
                        busy      <= 1'b0;
                        idx       <= '0;
                        stall_cnt <= '0;
                        state     <= ST_IDLE;
                    end else begin
                        stall_cnt <= stall_cnt + 1'b1;
                    end
`else
                    // Unreachable without readback.
                    state <= ST_IDLE;
`endif
                end

                ST_DONE: begin
                    // done/busy are registered, so the pulse appears in the
                    // first IDLE cycle, where a new start is already accepted.
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    idx   <= '0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
